// File: rtl/div_arbiter.sv
// div_arbiter: round-robin owner selection for one shared sequential divider.
// Zero divisors are answered locally with an all-ones quotient.
module div_arbiter #(
    parameter int N_REQ = 4,
    parameter int BITS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*BITS-1:0] req_dividend,
    input  logic [N_REQ*BITS-1:0] req_divisor,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic [BITS-1:0]       result,
    output logic                  busy,
    output logic                  div_start,
    output logic [BITS-1:0]       div_dividend,
    output logic [BITS-1:0]       div_divisor,
    input  logic                  div_ready,
    input  logic [BITS-1:0]       div_result
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ARM,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic          pick_vld;
    logic          div_zero;

    // (base + off) mod N_REQ for off in 1..N_REQ; one subtraction suffices.
    function automatic logic [IW-1:0] wrap_idx(
        input logic [IW-1:0] base,
        input int            off
    );
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IW'(s);
    endfunction

    always_comb begin
        pick_vld = 1'b0;
        pick     = last;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!pick_vld && req[wrap_idx(last, i)]) begin
                pick_vld = 1'b1;
                pick     = wrap_idx(last, i);
            end
        end
    end

    assign div_zero = (div_divisor == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_n = START;
                end
            end
            START: begin
                state_n = div_zero ? DONE : ARM;
            end
            ARM: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (div_ready) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operands are captured only at the grant edge; later req changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant        <= '0;
            result       <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            last         <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant        <= N_REQ'(1) << pick;
                        div_dividend <= req_dividend[pick*BITS +: BITS];
                        div_divisor  <= req_divisor[pick*BITS +: BITS];
                        last         <= pick;
                    end
                end
                START: begin
                    if (div_zero) begin
                        result <= '1;
                    end
                end
                WAIT: begin
                    if (div_ready) begin
                        result <= div_result;
                    end
                end
                DONE: begin
                    grant <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign div_start = (state == START) && !div_zero;
    assign done      = (state == DONE) ? grant : '0;

    a_grant_onehot : assert property (
        @(posedge clk) disable iff (reset) $onehot0(grant)
    );

    a_done_owner : assert property (
        @(posedge clk) disable iff (reset) (done == '0) || (done == grant)
    );

    a_start_owned : assert property (
        @(posedge clk) disable iff (reset) div_start |-> (grant != '0)
    );

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider model
// whose ready level stays high until one cycle after the next start.
module tb_div_arbiter;

    localparam int N = 4;
    localparam int B = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*B-1:0] req_dividend = '0;
    logic [N*B-1:0] req_divisor = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [B-1:0]   result;
    logic           busy;
    logic           div_start;
    logic [B-1:0]   div_dividend;
    logic [B-1:0]   div_divisor;
    logic           div_ready = 1'b0;
    logic [B-1:0]   div_result = '0;

    int checks = 0;
    int errors = 0;
    int lat_cfg = 2;
    int cnt = 0;
    logic [B-1:0] q_hold = '0;

    div_arbiter #(.N_REQ(N), .BITS(B)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_dividend(req_dividend),
        .req_divisor(req_divisor),
        .grant(grant),
        .done(done),
        .result(result),
        .busy(busy),
        .div_start(div_start),
        .div_dividend(div_dividend),
        .div_divisor(div_divisor),
        .div_ready(div_ready),
        .div_result(div_result)
    );

    always #5 clk = ~clk;

    // Divider model: ready at (start cycle + lat_cfg); never reset by the arbiter.
    always_ff @(posedge clk) begin
        if (div_start) begin
            cnt    <= lat_cfg - 1;
            q_hold <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
        end else if (cnt != 0) begin
            cnt       <= cnt - 1;
            div_ready <= (cnt == 1);
            if (cnt == 1) begin
                div_result <= q_hold;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_grant"}, grant, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_result"}, result, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_start"}, div_start, 0);
        chk({name, "_dvd"}, div_dividend, 0);
        chk({name, "_dvs"}, div_divisor, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
    endtask

    // Called in the IDLE cycle that is cycle 0 of the operation.
    task automatic run_op(input string name, input logic [N-1:0] mask,
                          input logic [N*B-1:0] dvd,
                          input logic [N*B-1:0] dvs, input int lat,
                          input logic [N-1:0] eg, input logic [B-1:0] er,
                          input int edone, input bit estart);
        req_dividend = dvd;
        req_divisor  = dvs;
        lat_cfg      = lat;
        req          = mask;
        for (int c = 1; c <= edone + 1; c++) begin
            tick();
            if (c < edone) begin
                chk({name, "_grant"}, grant, eg);
                chk({name, "_done_early"}, done, 0);
                chk({name, "_busy"}, busy, 1);
                chk({name, "_start"}, div_start, (c == 1) && estart);
            end else if (c == edone) begin
                chk({name, "_grant_d"}, grant, eg);
                chk({name, "_done"}, done, eg);
                chk({name, "_result"}, result, er);
                chk({name, "_start_d"}, div_start, 0);
            end else begin
                chk({name, "_busy_after"}, busy, 0);
                chk({name, "_grant_after"}, grant, 0);
                chk({name, "_done_after"}, done, 0);
                chk({name, "_result_hold"}, result, er);
            end
            if (c == 2) begin
                req          = '0;
                req_dividend = ~dvd;
                req_divisor  = dvs + 1;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0]   mask;
        logic [N*B-1:0] dvd;
        logic [N*B-1:0] dvs;
        int             lat;
        logic [N-1:0]   eg;
        logic [B-1:0]   er;
        int             edone;
        bit             estart;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        int model_last;
        logic [N-1:0]   m;
        logic [N*B-1:0] rd;
        logic [N*B-1:0] rs;
        int lat;
        int win;
        logic [B-1:0] a;
        logic [B-1:0] d;

        vecs[0] = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd100},
                    {16'd0, 16'd0, 16'd0, 16'd7}, 4, 4'b0001, 16'd14, 6, 1'b1};
        vecs[1] = '{4'b0100, {16'd0, 16'd55, 16'd0, 16'd0},
                    {16'd0, 16'd0, 16'd0, 16'd0}, 4, 4'b0100, 16'hFFFF, 2, 1'b0};
        vecs[2] = '{4'b0010, {16'd0, 16'd0, 16'd90, 16'd0},
                    {16'd0, 16'd0, 16'd9, 16'd0}, 3, 4'b0010, 16'd10, 5, 1'b1};
        vecs[3] = '{4'b1111, {16'd8, 16'd200, 16'd6, 16'd5},
                    {16'd1, 16'd3, 16'd1, 16'd1}, 2, 4'b0100, 16'd66, 4, 1'b1};
        vecs[4] = '{4'b0011, {16'd0, 16'd0, 16'd50, 16'd7},
                    {16'd0, 16'd0, 16'd5, 16'd9}, 5, 4'b0001, 16'd0, 7, 1'b1};
        vecs[5] = '{4'b1000, {16'hFFFF, 16'd0, 16'd0, 16'd0},
                    {16'd1, 16'd0, 16'd0, 16'd0}, 2, 4'b1000, 16'hFFFF, 4, 1'b1};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].mask, vecs[i].dvd,
                   vecs[i].dvs, vecs[i].lat, vecs[i].eg, vecs[i].er,
                   vecs[i].edone, vecs[i].estart);
        end

        // Fairness with all requests held continuously.
        do_reset();
        lat_cfg      = 2;
        req_dividend = {16'd13, 16'd12, 16'd11, 16'd10};
        req_divisor  = {16'd1, 16'd1, 16'd1, 16'd1};
        req          = 4'b1111;
        n = 0;
        for (int c = 0; c < 80 && n < 5; c++) begin
            tick();
            chk("fair_onehot", $onehot0(grant), 1);
            if (done != '0) begin
                chk("fair_grant", done, 64'(1) << (n % N));
                chk("fair_done_owner", grant, done);
                chk("fair_result", result, 10 + (n % N));
                n++;
                if (n == 5) begin
                    req = '0;
                end
            end
        end
        chk("fair_count", n, 5);
        req = '0;
        tick();
        tick();
        chk("fair_idle", busy, 0);

        // Reset while waiting on the divider; the late ready must be ignored.
        do_reset();
        lat_cfg      = 4;
        req_dividend = {16'd0, 16'd0, 16'd0, 16'd100};
        req_divisor  = {16'd0, 16'd0, 16'd0, 16'd7};
        req          = 4'b0001;
        tick();
        chk("rst_grant", grant, 4'b0001);
        req = '0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("rst_no_done", done, 0);
            chk("rst_busy", busy, 1);
        end
        reset = 1'b1;
        tick();
        chk_reset_vals("rst_mid");
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_late_done", done, 0);
            chk("rst_late_busy", busy, 0);
            chk("rst_late_result", result, 0);
        end
        run_op("post_rst", 4'b1000, {16'd20, 16'd0, 16'd0, 16'd0},
               {16'd4, 16'd0, 16'd0, 16'd0}, 2, 4'b1000, 16'd5, 4, 1'b1);

        // Randomised operations against a round-robin / arithmetic model.
        do_reset();
        model_last = N - 1;
        for (int it = 0; it < 40; it++) begin
            m   = 4'($urandom_range(1, 15));
            lat = $urandom_range(2, 6);
            for (int k = 0; k < N; k++) begin
                rd[k*B +: B] = 16'($urandom_range(0, 65535));
                rs[k*B +: B] = ($urandom_range(0, 4) == 0) ? 16'd0 :
                               16'($urandom_range(1, 300));
            end
            win = -1;
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && m[(model_last + k) % N]) begin
                    win = (model_last + k) % N;
                end
            end
            a = rd[win*B +: B];
            d = rs[win*B +: B];
            run_op($sformatf("rnd%0d", it), m, rd, rs, lat,
                   4'(1 << win), (d == 0) ? 16'hFFFF : a / d,
                   (d == 0) ? 2 : lat + 2, d != 0);
            model_last = win;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
